// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM states, word-length encoding
// and the oversampling geometry used by the receive path.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE  = 16;
  localparam int unsigned UART_RX_MID_TICK = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_e;

  typedef enum logic [1:0] {
    WORD_LEN_5 = 2'b00,
    WORD_LEN_6 = 2'b01,
    WORD_LEN_7 = 2'b10,
    WORD_LEN_8 = 2'b11
  } uart_word_len_e;

  // Index of the final data bit for a given word length (5 bits -> 4 ... 8 bits -> 7).
  function automatic logic [2:0] last_bit_idx(input uart_word_len_e wl);
    return 3'd4 + {1'b0, wl};
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Synchronises the serial line and produces the per-bit sample and decision strobe.
// UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote over counter 6/7/8, decision at counter 8.
module uart_rx_bit_sampler
  import uart_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic [3:0] tick_cnt_i,
  input  logic       rx_i,
  output logic       rx_sync_o,
  output logic       bit_o,
  output logic       decide_o
);

  localparam logic [3:0] MidTick = 4'(UART_RX_MID_TICK);

  logic [SyncStages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], rx_i};
    end
  end

  assign rx_sync_o = sync_q[SyncStages-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // Samples taken at counter 6 and 7; the third vote is the live value at counter 8.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
    end else if (tick_i && (tick_cnt_i == MidTick - 4'd1 || tick_cnt_i == MidTick)) begin
      hist_q <= {hist_q[0], rx_sync_o};
    end
  end

  assign decide_o = tick_i && (tick_cnt_i == MidTick + 4'd1);
  assign bit_o    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync_o) | (hist_q[0] & rx_sync_o);
`else
  assign decide_o = tick_i && (tick_cnt_i == MidTick);
  assign bit_o    = rx_sync_o;
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: start detection, 5-8 bit framing with parity/framing/break
// status and a one-entry valid/ready holding register. Honours UART_RX_MAJORITY_VOTE_EN.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       oversample_rate_edge_i,
  input  logic       rx_i,
  input  logic [1:0] word_len_i,
  input  logic       parity_en_i,
  input  logic       even_parity_i,
  input  logic       stick_parity_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       parity_err_o,
  output logic       framing_err_o,
  output logic       break_o,
  output logic       overrun_o,
  output logic       rx_busy_o
);

  uart_rx_state_e state_q, state_d;
  uart_word_len_e wlen_q, wlen_d;
  logic [3:0] cnt_q, cnt_d, cnt_tick;
  logic       armed_q, armed_d;
  logic       par_en_q, par_en_d, even_q, even_d, stick_q, stick_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_bit_q, par_bit_d;

  logic       rx_sync, bit_val, decide;
  logic       complete, exp_par, char_perr, char_ferr, char_brk;

  logic [7:0] data_q;
  logic       valid_q, perr_q, ferr_q, brk_q, ovr_q;

  // The sampler sees the counter value this tick moves to, so tick k after start
  // detection carries counter k mod 16.
  assign cnt_tick = cnt_q + 4'd1;

  uart_rx_bit_sampler #(
    .SyncStages(SyncStages)
  ) u_sampler (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .tick_i    (oversample_rate_edge_i),
    .tick_cnt_i(cnt_tick),
    .rx_i      (rx_i),
    .rx_sync_o (rx_sync),
    .bit_o     (bit_val),
    .decide_o  (decide)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RX_IDLE;
      wlen_q    <= WORD_LEN_8;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      par_en_q  <= 1'b0;
      even_q    <= 1'b0;
      stick_q   <= 1'b0;
      shift_q   <= '0;
      idx_q     <= '0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wlen_q    <= wlen_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      par_en_q  <= par_en_d;
      even_q    <= even_d;
      stick_q   <= stick_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      par_bit_q <= par_bit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wlen_d    = wlen_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    par_en_d  = par_en_q;
    even_d    = even_q;
    stick_d   = stick_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    par_bit_d = par_bit_q;
    complete  = 1'b0;

    if (oversample_rate_edge_i && state_q != RX_IDLE) cnt_d = cnt_tick;

    case (state_q)
      RX_IDLE: begin
        if (oversample_rate_edge_i) begin
          if (rx_sync) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d   = RX_START;
            cnt_d     = '0;
            wlen_d    = uart_word_len_e'(word_len_i);
            par_en_d  = parity_en_i;
            even_d    = even_parity_i;
            stick_d   = stick_parity_i;
            shift_d   = '0;
            idx_d     = '0;
            par_bit_d = 1'b0;
          end
        end
      end
      RX_START: begin
        // A high start bit is a false start; IDLE stays armed.
        if (decide) state_d = bit_val ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (decide) begin
          shift_d[idx_q] = bit_val;
          if (idx_q == last_bit_idx(wlen_q)) begin
            state_d = par_en_q ? RX_PARITY : RX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (decide) begin
          par_bit_d = bit_val;
          state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (decide) begin
          complete = 1'b1;
          state_d  = RX_IDLE;
          armed_d  = 1'b0;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Unused upper data bits stay 0, so the reduction covers only received bits.
  assign exp_par   = stick_q ? ~even_q : (even_q ? ^shift_q : ~(^shift_q));
  assign char_perr = par_en_q & (par_bit_q ^ exp_par);
  assign char_ferr = ~bit_val;
  assign char_brk  = (shift_q == '0) & ~(par_en_q & par_bit_q) & ~bit_val;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= complete & valid_q & ~rx_ready_i;
      if (complete && (!valid_q || rx_ready_i)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        perr_q  <= char_perr;
        ferr_q  <= char_ferr;
        brk_q   <= char_brk;
      end else if (valid_q && rx_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign parity_err_o  = perr_q;
  assign framing_err_o = ferr_q;
  assign break_o       = brk_q;
  assign overrun_o     = ovr_q;
  assign rx_busy_o     = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: scoreboard of expected characters
// against characters popped from the holding register.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int unsigned SYNC = 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int  DEC_OFS = 8;
  localparam bit  MAJ     = 1'b1;
`else
  localparam int  DEC_OFS = 7;
  localparam bit  MAJ     = 1'b0;
`endif
  // Posedges from driving the start edge to rx_valid_o rising, 8N1, tick every cycle.
  localparam int LAT = int'(SYNC) + 1 + 16 * 9 + DEC_OFS;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } chr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] word_len = 2'b11;
  logic       par_en = 1'b0, even = 1'b0, stick = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, perr, ferr, brk, ovr, busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ovr_cnt = 0;
  int   tick_div = 1;
  int   tick_ph = 0;
  chr_t exp_q[$];
  chr_t got_q[$];
  int   got_cyc_q[$];

  uart_rx_deserializer #(
    .SyncStages(SYNC)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .oversample_rate_edge_i(tick),
    .rx_i                  (rx),
    .word_len_i            (word_len),
    .parity_en_i           (par_en),
    .even_parity_i         (even),
    .stick_parity_i        (stick),
    .rx_data_o             (rx_data),
    .rx_valid_o            (rx_valid),
    .rx_ready_i            (ready),
    .parity_err_o          (perr),
    .framing_err_o         (ferr),
    .break_o               (brk),
    .overrun_o             (ovr),
    .rx_busy_o             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tick_ph = (tick_ph + 1 >= tick_div) ? 0 : tick_ph + 1;
    tick    = (tick_ph == 0);
  end

  always @(negedge clk) begin
    if (rst_n && rx_valid && ready) begin
      got_q.push_back(chr_t'({rx_data, perr, ferr, brk}));
      got_cyc_q.push_back(cyc);
    end
    if (ovr) ovr_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic chr_t model(input logic [7:0] d, input int nbits, input logic pe, input logic pv,
                                 input logic sv, input logic ev, input logic st);
    chr_t c;
    logic x;
    c.data = '0;
    x = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      c.data[i] = d[i];
      x ^= d[i];
    end
    c.perr = pe && (pv != (st ? !ev : (ev ? x : !x)));
    c.ferr = !sv;
    c.brk  = (c.data == 8'h00) && !(pe && pv) && !sv;
    return c;
  endfunction

  // Hold the line at v for n oversample ticks; returns 1ns after the last tick edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pe, input logic pv,
                            input logic sv, input bit scramble);
    logic [1:0] wl;
    logic p, e, s;
    wl = word_len; p = par_en; e = even; s = stick;
    hold(1'b0, 16);
    if (scramble) begin
      word_len = 2'($urandom);
      par_en   = 1'($urandom);
      even     = 1'($urandom);
      stick    = 1'($urandom);
    end
    for (int i = 0; i < nbits; i++) hold(d[i], 16);
    if (pe) hold(pv, 16);
    hold(sv, 16);
    word_len = wl; par_en = p; even = e; stick = s;
  endtask

  task automatic take(input int budget, output bit ok, output chr_t g, output chr_t e, output int gc);
    ok = 1'b0;
    g  = '0;
    gc = 0;
    for (int i = 0; i < budget && got_q.size() == 0; i++) @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (got_q.size() > 0) begin
      ok = 1'b1;
      g  = got_q.pop_front();
      gc = got_cyc_q.pop_front();
    end
  endtask

  task automatic set_cfg(input int nbits, input logic pe, input logic ev, input logic st);
    word_len = 2'(nbits - 5);
    par_en = pe; even = ev; stick = st;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rx_data, rx_valid, perr, ferr, brk, ovr, busy} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_in: got %h want 0", {rx_data, rx_valid, perr, ferr, brk, ovr, busy});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    hold(1'b1, 8);
    n_cmp++;
    if ({rx_data, rx_valid, perr, ferr, brk, ovr, busy} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want 0", {rx_data, rx_valid, perr, ferr, brk, ovr, busy});
    end
  endtask

  task automatic test_8n1;
    int p, gc;
    bit ok;
    chr_t g, e;
    set_cfg(8, 0, 0, 0);
    ready = 1'b1;
    hold(1'b1, 20);
    p = cyc;
    exp_q.push_back(model(8'hA5, 8, 0, 0, 1, 0, 0));
    send_frame(8'hA5, 8, 0, 0, 1, 0);
    hold(1'b1, 16);
    take(400, ok, g, e, gc);
    n_cmp++;
    if (!ok || g !== e) begin
      n_bad++;
      $display("FAIL 8n1_char: got %h (ok=%0d) want %h", g, ok, e);
    end
    n_cmp++;
    if (gc - p != LAT) begin
      n_bad++;
      $display("FAIL 8n1_latency: got %0d want %0d", gc - p, LAT);
    end
    n_cmp++;
    if ({rx_valid, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL 8n1_idle: got valid/busy %b want 00", {rx_valid, busy});
    end
  endtask

  task automatic test_parity;
    // data, nbits, even, stick, parity bit sent, stop bit sent, scramble mid-frame
    logic [7:0] td[4] = '{8'h35, 8'h2B, 8'h13, 8'hFF};
    int         tn[4] = '{7, 6, 5, 8};
    logic       tev[4] = '{1, 0, 0, 1};
    logic       tst[4] = '{0, 0, 1, 0};
    logic       tpv[4] = '{1, 1, 0, 0};
    logic       tsv[4] = '{1, 1, 1, 0};
    int gc;
    bit ok;
    chr_t g, e;
    for (int i = 0; i < 4; i++) begin
      set_cfg(tn[i], 1'b1, tev[i], tst[i]);
      hold(1'b1, 8);
      exp_q.push_back(model(td[i], tn[i], 1'b1, tpv[i], tsv[i], tev[i], tst[i]));
      send_frame(td[i], tn[i], 1'b1, tpv[i], tsv[i], i == 1);
      hold(1'b1, 16);
      take(400, ok, g, e, gc);
      n_cmp++;
      if (!ok || g !== e) begin
        n_bad++;
        $display("FAIL parity_case%0d: got %h (ok=%0d) want %h", i, g, ok, e);
      end
    end
    set_cfg(8, 0, 0, 0);
  endtask

  task automatic test_glitch;
    int gc;
    bit ok;
    chr_t g, e;
    hold(1'b1, 8);
    hold(1'b0, 4);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_busy_on: got %b want 1", busy);
    end
    hold(1'b1, 12);
    n_cmp++;
    if (busy !== 1'b0 || got_q.size() != 0) begin
      n_bad++;
      $display("FAIL glitch_false_start: got busy=%b chars=%0d want busy=0 chars=0", busy, got_q.size());
    end
    exp_q.push_back(model(8'h5A, 8, 0, 0, 1, 0, 0));
    send_frame(8'h5A, 8, 0, 0, 1, 0);
    hold(1'b1, 16);
    take(400, ok, g, e, gc);
    n_cmp++;
    if (!ok || g !== e) begin
      n_bad++;
      $display("FAIL glitch_next_frame: got %h (ok=%0d) want %h", g, ok, e);
    end
  endtask

  task automatic test_break;
    int gc;
    bit ok;
    chr_t g, e;
    hold(1'b1, 8);
    exp_q.push_back(model(8'h00, 8, 0, 0, 0, 0, 0));
    hold(1'b0, 40 * 16);
    hold(1'b1, 32);
    take(10, ok, g, e, gc);
    n_cmp++;
    if (!ok || g !== e) begin
      n_bad++;
      $display("FAIL break_char: got %h (ok=%0d) want %h", g, ok, e);
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++;
      $display("FAIL break_single: got %0d extra chars want 0", got_q.size());
    end
    exp_q.push_back(model(8'h3C, 8, 0, 0, 1, 0, 0));
    send_frame(8'h3C, 8, 0, 0, 1, 0);
    hold(1'b1, 16);
    take(400, ok, g, e, gc);
    n_cmp++;
    if (!ok || g !== e) begin
      n_bad++;
      $display("FAIL break_recover: got %h (ok=%0d) want %h", g, ok, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] td[3] = '{8'h01, 8'h80, 8'h7E};
    int gc;
    bit ok;
    chr_t g, e;
    hold(1'b1, 8);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(td[i], 8, 0, 0, 1, 0, 0));
      send_frame(td[i], 8, 0, 0, 1, 0);
    end
    hold(1'b1, 16);
    for (int i = 0; i < 3; i++) begin
      take(400, ok, g, e, gc);
      n_cmp++;
      if (!ok || g !== e) begin
        n_bad++;
        $display("FAIL b2b_char%0d: got %h (ok=%0d) want %h", i, g, ok, e);
      end
    end
  endtask

  task automatic test_overrun;
    int o0, o1, gc;
    bit ok;
    chr_t g, e;
    ready = 1'b0;
    hold(1'b1, 8);
    o0 = ovr_cnt;
    exp_q.push_back(model(8'h11, 8, 0, 0, 1, 0, 0));
    send_frame(8'h11, 8, 0, 0, 1, 0);
    hold(1'b1, 4);
    send_frame(8'h22, 8, 0, 0, 1, 0);
    hold(1'b1, 16);
    n_cmp++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h11} || ovr_cnt - o0 != 1) begin
      n_bad++;
      $display("FAIL overrun_drop: got valid=%b data=%h pulses=%0d want 1 11 1", rx_valid, rx_data, ovr_cnt - o0);
    end
    o1 = ovr_cnt;
    exp_q.push_back(model(8'h33, 8, 0, 0, 1, 0, 0));
    fork
      send_frame(8'h33, 8, 0, 0, 1, 0);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    hold(1'b1, 8);
    take(10, ok, g, e, gc);
    n_cmp++;
    if (!ok || g !== e) begin
      n_bad++;
      $display("FAIL overrun_pop_old: got %h (ok=%0d) want %h", g, ok, e);
    end
    n_cmp++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h33} || ovr_cnt != o1) begin
      n_bad++;
      $display("FAIL overrun_pop_load: got valid=%b data=%h pulses=%0d want 1 33 0", rx_valid, rx_data, ovr_cnt - o1);
    end
    ready = 1'b1;
    take(20, ok, g, e, gc);
    n_cmp++;
    if (!ok || g !== e) begin
      n_bad++;
      $display("FAIL overrun_third: got %h (ok=%0d) want %h", g, ok, e);
    end
  endtask

  task automatic test_noise;
    int gc;
    bit ok;
    chr_t g, e;
    e = model(MAJ ? 8'h00 : 8'h08, 8, 0, 0, 1, 0, 0);
    exp_q.push_back(e);
    hold(1'b1, 8);
    hold(1'b0, 16 * 4);
    hold(1'b0, 7);
    hold(1'b1, 1);
    hold(1'b0, 8 + 16 * 4);
    hold(1'b1, 32);
    take(10, ok, g, e, gc);
    n_cmp++;
    if (!ok || g !== e) begin
      n_bad++;
      $display("FAIL noise_bit3: got %h (ok=%0d) want %h", g, ok, e);
    end
  endtask

  task automatic test_slow_tick;
    int gc;
    bit ok;
    chr_t g, e;
    tick_div = 3;
    set_cfg(8, 1, 0, 0);
    hold(1'b1, 8);
    exp_q.push_back(model(8'h96, 8, 1, 1, 1, 0, 0));
    send_frame(8'h96, 8, 1, 1, 1, 0);
    hold(1'b1, 16);
    take(100, ok, g, e, gc);
    n_cmp++;
    if (!ok || g !== e) begin
      n_bad++;
      $display("FAIL slow_tick_char: got %h (ok=%0d) want %h", g, ok, e);
    end
    tick_div = 1;
    set_cfg(8, 0, 0, 0);
    hold(1'b1, 4);
  endtask

  task automatic test_reset_midframe;
    ready = 1'b0;
    hold(1'b1, 8);
    send_frame(8'h44, 8, 0, 0, 1, 0);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 5);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rx_valid, busy, rx_data} !== 10'h0) begin
      n_bad++;
      $display("FAIL midframe_reset: got valid=%b busy=%b data=%h want 0 0 00", rx_valid, busy, rx_data);
    end
    hold(1'b1, 40);
    rst_n = 1'b1;
    ready = 1'b1;
    hold(1'b1, 200);
    n_cmp++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midframe_discard: got chars=%0d busy=%b want 0 0", got_q.size(), busy);
    end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_glitch;
    test_break;
    test_back_to_back;
    test_overrun;
    test_noise;
    test_slow_tick;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive half of the UART: consumes the 16x oversample tick from the baud generator, synchronises the asynchronous serial line, finds start bits, samples each bit at its centre, and assembles 5–8-bit characters with parity, framing and break status. Completed characters go to a one-entry holding register with a valid/ready handshake toward the RX FIFO/register interface.

## Interface
- `SyncStages`, default 2: number of flip-flops in the `rx_i` synchroniser (≥2).
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `oversample_rate_edge_i` in 1: single-cycle 16x baud tick enable.
- `rx_i` in 1: serial line, asynchronous, idle high.
- `word_len_i` in 2: 00=5 … 11=8 data bits.
- `parity_en_i` in 1: parity bit present.
- `even_parity_i` in 1: even (1) / odd (0).
- `stick_parity_i` in 1: expected parity bit = ~`even_parity_i`.
- `rx_data_o` out 8: character, LSB-aligned, unused upper bits 0.
- `rx_valid_o` out 1: holding register full.
- `rx_ready_i` in 1: consumer accepts.
- `parity_err_o`, `framing_err_o`, `break_o` out 1 each: status of the held character, valid with `rx_valid_o`.
- `overrun_o` out 1: single-cycle pulse, character lost.
- `rx_busy_o` out 1: FSM not in IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Tick counter: 4 bits. It advances only on `oversample_rate_edge_i` and wraps 15→0. Without ticks the FSM is frozen.
- IDLE:
  - Arms once a tick samples the synchronised line high.
  - When armed, a tick that samples it low moves to START, with counter=0.
  - On that transition, `word_len_i`, `parity_en_i`, `even_parity_i` and `stick_parity_i` are latched. Changes mid-frame have no effect.
- Bit decision point: counter==7 (single-sample build).
- START: at the decision point:
  - Line high: false start, return to IDLE, which is still armed.
  - Line low: go to DATA.
- DATA:
  - One bit per decision point, shifted in LSB first.
  - After the latched word length, go to PARITY if enabled, else STOP.
- PARITY: compare the received bit with the expected value; a mismatch sets the parity error.
  - Even: XOR of data bits.
  - Odd: its inverse.
  - Stick: ~`even_parity_i`.
- STOP:
  - Sampled low: framing error.
  - Data, parity (if present) and stop all 0: break, data 0x00.
  - Character completes at this decision point; return to IDLE un-armed.
- Only the first stop bit is checked.
- Holding register:
  - Loads when a character completes and the register is empty or being popped (`rx_valid_o & rx_ready_i`) in the same cycle.
  - Full and not popped: the new character is dropped and `overrun_o` pulses. The held character and its flags are unchanged.

## Timing
- Reset values: `rx_data_o`=0, `rx_valid_o`=0, all status flags 0, `overrun_o`=0, `rx_busy_o`=0. FSM goes to IDLE un-armed and the synchroniser resets to 1.
- Start detection lags the line by `SyncStages` cycles plus the wait to the next tick.
- Bit n (start=0) is decided at tick 16n+7 after start detection.
- 8N1 stop decision: tick 151. `rx_valid_o`, data and flags register in the cycle after the decision tick.
- `overrun_o` is asserted in the cycle after the decision tick.
- Handshake: transfer on `rx_valid_o & rx_ready_i`. `rx_valid_o` deasserts the next cycle unless a new load coincides.
- Reset mid-frame: frame discarded, holding register cleared.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined:
  - Each bit is the 2-of-3 majority of samples at counter 6, 7, 8.
  - Decision point moves to counter==8, so everything above that is tied to the decision point shifts one tick later (8N1 stop at tick 152).
  - A start-bit majority high is a false start.
- Undefined: single sample at counter==7, no sample history registers.

## Structure
- Goes in `uart_pkg`:
  - `uart_rx_state_e` enum.
  - `uart_word_len_e` typedef.
  - Constants `UART_OVERSAMPLE=16`.
  - `UART_RX_MID_TICK=7`.
- Reuse the common_cells `FF` macros.
- One sub-module, `uart_rx_bit_sampler`: `rx_i` synchroniser, plus sample history and majority logic under the macro. Its output is the sampled bit value and a decision strobe.

## Test plan
- **8N1, 0xA5**: tick every cycle, line held for exact 16-tick bits → `rx_data_o`=0xA5 and `rx_valid_o` one cycle after tick 151 from start detect (152 with macro), all flags 0.
- **7E1, 0x35, parity bit 1** (expected 0) → data 0x35, `parity_err_o`=1, `framing_err_o`=0.
- **Glitch**: `rx_i` low for 4 ticks, then high → no `rx_valid_o`; `rx_busy_o` falls after the start decision; the next real frame (0x5A) is received correctly.
- **Break**: `rx_i` low for 40 bit times, 8N1 → exactly one character 0x00 with `break_o`=1 and `framing_err_o`=1; no further character until the line returns high and a new start arrives.
- **Overrun**: `rx_ready_i`=0, send 0x11 then 0x22 → `rx_data_o` stays 0x11, `overrun_o` pulses once. Then pop on the same cycle a third character 0x33 completes → 0x33 loaded, no overrun.
- **Noise**: 1-tick glitch at counter 7 of data bit 3 of 0x00 → with `UART_RX_MAJORITY_VOTE_EN`, data 0x00; without it, data 0x08.
